// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with configurable wait states and ERROR responses.
module ahb_sram_slave #(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);
  localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;
  state_t        state;
  logic [2:0]    cnt;
  logic          pend, wr, accept, err, done;
  logic [AW-1:0] idx;
  logic [3:0]    be, be_in;
  logic [31:0]   mem [MEM_DEPTH];
  logic          unused;
  assign unused = ^{HBURST, HMASTLOCK, HADDR[31:14]};
  // HREADYOUT gate keeps a stray HREADY during our own wait cycles from starting a transfer
  assign accept = HSEL && HREADY && HTRANS[1] && HREADYOUT;
  assign err = HSIZE > 3'b010 || (HSIZE == 3'b001 && HADDR[0]) ||
               (HSIZE == 3'b010 && HADDR[1:0] != 2'b00) || {1'b0, HADDR[13:2]} >= 13'(MEM_DEPTH);
  assign be_in = HSIZE == 3'b000 ? 4'b0001 << HADDR[1:0] :
                 HSIZE == 3'b001 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // pend is only set for OKAY transfers, so HREADYOUT high with pend marks the completing cycle
  assign done = pend && HREADYOUT;
  assign HRDATA = done && !wr ? mem[idx] : 32'h0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= 2'b00;
    end else begin
      case (state)
        IDLE, ERR2: begin
          pend      <= accept && !err;
          state     <= !accept ? IDLE : err ? ERR1 : WAIT_STATES > 0 ? WAIT : IDLE;
          HREADYOUT <= !accept || (!err && WAIT_STATES == 0);
          HRESP     <= {1'b0, accept && err};
          cnt       <= accept ? 3'(WAIT_STATES - 1) : cnt;
        end
        WAIT: begin
          state     <= cnt == 3'd0 ? IDLE : WAIT;
          HREADYOUT <= cnt == 3'd0;
          cnt       <= cnt - 3'(cnt != 3'd0);
        end
        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 2'b01;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      idx <= HADDR[AW+1:2];
      wr  <= HWRITE;
      be  <= be_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && done && wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
  end
endmodule
